// File: rtl/ccw_xfer_sched_pkg.sv
// Shared HSI configuration: clock frequency, busy-repeat default, line encoding
// and the transfer scheduler state type.
package ccw_xfer_sched_pkg;

  localparam int unsigned HSI_CLK_FREQ     = 50_000_000;
  localparam int unsigned HSI_MAX_BUSY_RPT = 3;

  localparam logic LINE_MAIN    = 1'b0;
  localparam logic LINE_RESERVE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_TX,
    ST_WAIT_REPLY,
    ST_BUSY_DELAY
  } xfer_state_e;

  // Bits needed to hold max_val, never less than one.
  function automatic int unsigned width_for(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ccw_tick_timer.sv
// Saturating cycle counter: load clears it, enable advances it, expired flags
// the cycle on which the count has reached the programmed last value.
module ccw_tick_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] last,
  output logic         expired
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (enable && (cnt_q < last)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && !load && (cnt_q >= last);

endmodule

// File: rtl/ccw_xfer_sched.sv
// Two-source CCW transaction scheduler: round-robin grant, reply wait with
// line failover, and delayed repeats while the device reports busy.
module ccw_xfer_sched
  import ccw_xfer_sched_pkg::*;
#(
  parameter int unsigned CLK_FREQ          = HSI_CLK_FREQ,
  parameter int unsigned REPLY_TIMEOUT_CYC = CLK_FREQ / 50000,
  parameter int unsigned BUSY_DELAY_CYC    = CLK_FREQ / 10,
  parameter int unsigned MAX_BUSY_RPT      = HSI_MAX_BUSY_RPT
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output logic       tx_start,
  input  logic       tx_done,
  input  logic       reply_ok,
  input  logic       sd_busy,
  input  logic       reply_err,
  output logic       line_sel,
  output logic       xfer_done,
  output logic       xfer_fail,
  output logic       busy
);

  localparam int unsigned TMR_W  = width_for((REPLY_TIMEOUT_CYC > BUSY_DELAY_CYC) ?
                                             REPLY_TIMEOUT_CYC : BUSY_DELAY_CYC);
  localparam int unsigned BCNT_W = width_for(MAX_BUSY_RPT);

  localparam logic [TMR_W-1:0]  REPLY_LAST = TMR_W'(REPLY_TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0]  BUSY_LAST  = TMR_W'(BUSY_DELAY_CYC - 1);
  localparam logic [BCNT_W-1:0] BUSY_MAX   = BCNT_W'(MAX_BUSY_RPT);

  xfer_state_e       state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              line_sel_q, line_sel_d;
  logic              line_retry_q, line_retry_d;
  logic [BCNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic              rr_q, rr_d;
  logic              xfer_done_q, xfer_done_d;
  logic              xfer_fail_q, xfer_fail_d;

  logic              tmr_load;
  logic              tmr_en;
  logic [TMR_W-1:0]  tmr_last;
  logic              tmr_expired;

  // Reply wait and busy pause never overlap, so one counter serves both.
  assign tmr_en   = (state_q == ST_WAIT_REPLY) || (state_q == ST_BUSY_DELAY);
  assign tmr_last = (state_q == ST_BUSY_DELAY) ? BUSY_LAST : REPLY_LAST;

  ccw_tick_timer #(
    .W (TMR_W)
  ) u_tick_timer (
    .clk     (clk),
    .n_rst   (n_rst),
    .load    (tmr_load),
    .enable  (tmr_en),
    .last    (tmr_last),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    line_sel_d   = line_sel_q;
    line_retry_d = line_retry_q;
    busy_cnt_d   = busy_cnt_q;
    rr_d         = rr_q;
    xfer_done_d  = 1'b0;
    xfer_fail_d  = 1'b0;
    tmr_load     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          if (req == 2'b11) begin
            grant_d = rr_q ? 2'b10 : 2'b01;
          end else begin
            grant_d = req;
          end
          busy_cnt_d   = '0;
          line_retry_d = 1'b0;
          state_d      = ST_SEND;
        end
      end

      ST_SEND: begin
        state_d = ST_WAIT_TX;
      end

      ST_WAIT_TX: begin
        if (tx_done) begin
          tmr_load = 1'b1;
          state_d  = ST_WAIT_REPLY;
        end
      end

      ST_WAIT_REPLY: begin
        // Line fault (corrupt reply or silence): one failover, then give up.
        if (reply_err || (!sd_busy && !reply_ok && tmr_expired)) begin
          if (!line_retry_q) begin
            line_sel_d   = (line_sel_q == LINE_MAIN) ? LINE_RESERVE : LINE_MAIN;
            line_retry_d = 1'b1;
            state_d      = ST_SEND;
          end else begin
            xfer_fail_d = 1'b1;
            grant_d     = 2'b00;
            rr_d        = ~rr_q;
            state_d     = ST_IDLE;
          end
        end else if (sd_busy) begin
          if (busy_cnt_q < BUSY_MAX) begin
            busy_cnt_d = busy_cnt_q + BCNT_W'(1);
            tmr_load   = 1'b1;
            state_d    = ST_BUSY_DELAY;
          end else begin
            xfer_fail_d = 1'b1;
            grant_d     = 2'b00;
            rr_d        = ~rr_q;
            state_d     = ST_IDLE;
          end
        end else if (reply_ok) begin
          xfer_done_d = 1'b1;
          grant_d     = 2'b00;
          rr_d        = ~rr_q;
          state_d     = ST_IDLE;
        end
      end

      ST_BUSY_DELAY: begin
        if (tmr_expired) begin
          state_d = ST_SEND;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= 2'b00;
      line_sel_q   <= LINE_MAIN;
      line_retry_q <= 1'b0;
      busy_cnt_q   <= '0;
      rr_q         <= 1'b0;
      xfer_done_q  <= 1'b0;
      xfer_fail_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      line_sel_q   <= line_sel_d;
      line_retry_q <= line_retry_d;
      busy_cnt_q   <= busy_cnt_d;
      rr_q         <= rr_d;
      xfer_done_q  <= xfer_done_d;
      xfer_fail_q  <= xfer_fail_d;
    end
  end

  assign grant     = grant_q;
  assign tx_start  = (state_q == ST_SEND);
  assign line_sel  = line_sel_q;
  assign xfer_done = xfer_done_q;
  assign xfer_fail = xfer_fail_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ccw_xfer_sched.sv
// Directed bench for ccw_xfer_sched with short reply/busy delays.
module tb_ccw_xfer_sched;

  localparam int RT = 20;
  localparam int BD = 10;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [1:0] req = 2'b00;
  logic       tx_done = 1'b0;
  logic       reply_ok = 1'b0;
  logic       sd_busy = 1'b0;
  logic       reply_err = 1'b0;
  logic [1:0] grant;
  logic       tx_start;
  logic       line_sel;
  logic       xfer_done;
  logic       xfer_fail;
  logic       busy;

  int total = 0;
  int bad = 0;
  int n_tx = 0;
  int n_done = 0;
  int n_fail = 0;

  ccw_xfer_sched #(
    .CLK_FREQ          (50_000_000),
    .REPLY_TIMEOUT_CYC (RT),
    .BUSY_DELAY_CYC    (BD),
    .MAX_BUSY_RPT      (3)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .req       (req),
    .grant     (grant),
    .tx_start  (tx_start),
    .tx_done   (tx_done),
    .reply_ok  (reply_ok),
    .sd_busy   (sd_busy),
    .reply_err (reply_err),
    .line_sel  (line_sel),
    .xfer_done (xfer_done),
    .xfer_fail (xfer_fail),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_start)  n_tx   <= n_tx + 1;
    if (xfer_done) n_done <= n_done + 1;
    if (xfer_fail) n_fail <= n_fail + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  // Negedges until the selected output is seen high (0 tx_start, 1 xfer_done,
  // 2 xfer_fail); -1 when it never appears within the budget.
  task automatic wait_evt(input int sel, output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if ((sel == 0 && tx_start) || (sel == 1 && xfer_done) || (sel == 2 && xfer_fail)) begin
        n = i;
        break;
      end
    end
  endtask

  // Called on the negedge where tx_start is visible; tx_done lands in WAIT_TX.
  task automatic pulse_tx_done();
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic pulse_reply(input int kind);
    if (kind == 0) reply_ok = 1'b1;
    if (kind == 1) sd_busy = 1'b1;
    if (kind == 2) reply_err = 1'b1;
    @(negedge clk);
    reply_ok  = 1'b0;
    sd_busy   = 1'b0;
    reply_err = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({grant, tx_start, xfer_done, xfer_fail, busy, line_sel} !== 7'b0) begin
      $display("FAIL reset_outputs: got %b expected 0000000",
               {grant, tx_start, xfer_done, xfer_fail, busy, line_sel});
      bad++;
    end
    $display("reset: outs=%b", {grant, tx_start, xfer_done, xfer_fail, busy, line_sel});
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int n;
    int t0;
    #1 t0 = n_tx;
    req = 2'b01;
    wait_evt(0, n);
    total++;
    if (n !== 1) begin
      $display("FAIL single_tx_latency: got %0d expected 1", n); bad++;
    end
    total++;
    if (grant !== 2'b01) begin
      $display("FAIL single_grant: got %b expected 01", grant); bad++;
    end
    req = 2'b00;
    pulse_tx_done();
    repeat (4) @(negedge clk);
    pulse_reply(0);
    total++;
    if ({xfer_done, xfer_fail, grant, line_sel} !== 5'b10000) begin
      $display("FAIL single_done: got done/fail/grant/line=%b expected 10000",
               {xfer_done, xfer_fail, grant, line_sel}); bad++;
    end
    #1;
    total++;
    if (n_tx - t0 !== 1) begin
      $display("FAIL single_tx_count: got %0d expected 1", n_tx - t0); bad++;
    end
    $display("single: grant=01 tx=%0d done=%b line=%b", n_tx - t0, xfer_done, line_sel);
  endtask

  task automatic test_ignored_events();
    int d0;
    #1 d0 = n_done;
    tx_done = 1'b1; reply_ok = 1'b1; sd_busy = 1'b1; reply_err = 1'b1;
    @(negedge clk);
    tx_done = 1'b0; reply_ok = 1'b0; sd_busy = 1'b0; reply_err = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if ({busy, grant, tx_start} !== 4'b0 || n_done !== d0) begin
      $display("FAIL ignored_events: got busy/grant/tx=%b done_delta=%0d expected 0000 and 0",
               {busy, grant, tx_start}, n_done - d0); bad++;
    end
    $display("ignored: busy=%b grant=%b", busy, grant);
  endtask

  task automatic test_busy_repeat();
    int n;
    int t0;
    #1 t0 = n_tx;
    req = 2'b10;
    wait_evt(0, n);
    total++;
    if (grant !== 2'b10) begin
      $display("FAIL busy_rpt_grant: got %b expected 10", grant); bad++;
    end
    req = 2'b00;
    for (int i = 0; i < 3; i++) begin
      pulse_tx_done();
      pulse_reply(1);
      wait_evt(0, n);
      total++;
      if (n !== BD) begin
        $display("FAIL busy_rpt_delay%0d: got %0d expected %0d", i, n, BD); bad++;
      end
    end
    pulse_tx_done();
    pulse_reply(0);
    total++;
    if (xfer_done !== 1'b1) begin
      $display("FAIL busy_rpt_done: got %b expected 1", xfer_done); bad++;
    end
    #1;
    total++;
    if (n_tx - t0 !== 4) begin
      $display("FAIL busy_rpt_tx_count: got %0d expected 4", n_tx - t0); bad++;
    end
    $display("busy_repeat: tx=%0d done=%b", n_tx - t0, xfer_done);
  endtask

  task automatic test_busy_fail();
    int n;
    int t0;
    #1 t0 = n_tx;
    req = 2'b01;
    wait_evt(0, n);
    req = 2'b00;
    for (int i = 0; i < 4; i++) begin
      pulse_tx_done();
      pulse_reply(1);
      if (i < 3) wait_evt(0, n);
    end
    total++;
    if ({xfer_fail, xfer_done, grant} !== 4'b1000) begin
      $display("FAIL busy_fail_pulse: got fail/done/grant=%b expected 1000",
               {xfer_fail, xfer_done, grant}); bad++;
    end
    repeat (15) @(negedge clk);
    #1;
    total++;
    if (n_tx - t0 !== 4 || busy !== 1'b0) begin
      $display("FAIL busy_fail_tx_count: got tx=%0d busy=%b expected tx=4 busy=0",
               n_tx - t0, busy); bad++;
    end
    $display("busy_fail: tx=%0d busy=%b", n_tx - t0, busy);
  endtask

  task automatic test_timeout();
    int n;
    req = 2'b01;
    wait_evt(0, n);
    req = 2'b00;
    pulse_tx_done();
    wait_evt(0, n);
    total++;
    if (n !== RT || line_sel !== 1'b1) begin
      $display("FAIL timeout_resend: got cycles=%0d line=%b expected cycles=%0d line=1",
               n, line_sel, RT); bad++;
    end
    pulse_tx_done();
    wait_evt(2, n);
    total++;
    if (n !== RT || line_sel !== 1'b1) begin
      $display("FAIL timeout_fail: got cycles=%0d line=%b expected cycles=%0d line=1",
               n, line_sel, RT); bad++;
    end
    $display("timeout: fail after %0d cycles, line=%b", n, line_sel);
    // Next transaction starts on the reserve line, then fails over on a bad reply.
    req = 2'b10;
    wait_evt(0, n);
    req = 2'b00;
    total++;
    if (line_sel !== 1'b1 || grant !== 2'b10) begin
      $display("FAIL sticky_line: got line=%b grant=%b expected line=1 grant=10",
               line_sel, grant); bad++;
    end
    pulse_tx_done();
    pulse_reply(2);
    total++;
    if (tx_start !== 1'b1 || line_sel !== 1'b0) begin
      $display("FAIL err_failover: got tx=%b line=%b expected tx=1 line=0",
               tx_start, line_sel); bad++;
    end
    pulse_tx_done();
    pulse_reply(0);
    total++;
    if (xfer_done !== 1'b1 || line_sel !== 1'b0) begin
      $display("FAIL err_then_ok: got done=%b line=%b expected done=1 line=0",
               xfer_done, line_sel); bad++;
    end
    $display("reply_err: failover to line=%b done=%b", line_sel, xfer_done);
  endtask

  task automatic test_round_robin();
    int n;
    logic [1:0] exp_grant [3];
    exp_grant[0] = 2'b01;
    exp_grant[1] = 2'b10;
    exp_grant[2] = 2'b01;
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      wait_evt(0, n);
      total++;
      if (n !== 1 || grant !== exp_grant[i]) begin
        $display("FAIL rr_grant%0d: got latency=%0d grant=%b expected latency=1 grant=%b",
                 i, n, grant, exp_grant[i]); bad++;
      end
      if (i == 2) req = 2'b00;
      pulse_tx_done();
      pulse_reply(0);
      total++;
      if (xfer_done !== 1'b1) begin
        $display("FAIL rr_done%0d: got %b expected 1", i, xfer_done); bad++;
      end
      $display("round_robin %0d: grant=%b", i, exp_grant[i]);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int f0;
    req = 2'b01;
    wait_evt(0, n);
    req = 2'b00;
    pulse_tx_done();
    pulse_reply(2);
    pulse_tx_done();
    pulse_reply(1);
    total++;
    if (busy !== 1'b1 || line_sel !== 1'b1) begin
      $display("FAIL mid_precond: got busy=%b line=%b expected busy=1 line=1",
               busy, line_sel); bad++;
    end
    repeat (3) @(negedge clk);
    #1 f0 = n_fail;
    n_rst = 1'b0;
    #1;
    total++;
    if ({grant, tx_start, xfer_done, xfer_fail, busy, line_sel} !== 7'b0) begin
      $display("FAIL mid_reset_outputs: got %b expected 0000000",
               {grant, tx_start, xfer_done, xfer_fail, busy, line_sel}); bad++;
    end
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (n_fail !== f0) begin
      $display("FAIL mid_no_fail: got %0d fail pulses expected 0", n_fail - f0); bad++;
    end
    req = 2'b10;
    wait_evt(0, n);
    req = 2'b00;
    total++;
    if (n !== 1 || grant !== 2'b10 || line_sel !== 1'b0) begin
      $display("FAIL mid_restart: got latency=%0d grant=%b line=%b expected 1 10 0",
               n, grant, line_sel); bad++;
    end
    pulse_tx_done();
    pulse_reply(0);
    total++;
    if (xfer_done !== 1'b1) begin
      $display("FAIL mid_restart_done: got %b expected 1", xfer_done); bad++;
    end
    $display("reset_mid: restart grant=10 line=%b done=%b", line_sel, xfer_done);
  endtask

  initial begin
    test_reset();
    test_single();
    test_ignored_events();
    test_busy_repeat();
    test_busy_fail();
    test_timeout();
    test_round_robin();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
